// File: rtl/sp_ram_bist_pkg.sv
// Shared types for the sp_ram March BIST: controller states and march phase codes.
package sp_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W0_UP = 3'd1,
        RW_UP = 3'd2,
        RW_DN = 3'd3,
        R_DN  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_RW_UP = 2'd1;
    localparam logic [1:0] PH_RW_DN = 2'd2;
    localparam logic [1:0] PH_R_DN  = 2'd3;

endpackage

// File: rtl/sp_ram_bist_rd_pipe.sv
// Delay line that carries read context {valid, exp, addr, phase} alongside
// the RAM read latency so it arrives together with the returned dout.
module bist_rd_pipe #(
    parameter int WIDTH  = 8,
    parameter int ADDR   = 4,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_exp,
    input  logic [ADDR-1:0]  in_addr,
    input  logic [1:0]       in_phase,
    output logic             out_v,
    output logic [WIDTH-1:0] out_exp,
    output logic [ADDR-1:0]  out_addr,
    output logic [1:0]       out_phase
);

    logic             v_q     [RD_LAT];
    logic [WIDTH-1:0] exp_q   [RD_LAT];
    logic [ADDR-1:0]  addr_q  [RD_LAT];
    logic [1:0]       phase_q [RD_LAT];

    // Valid bits are cleared by reset so a reset mid-run leaves no stale compares.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) v_q[i] <= 1'b0;
        end else begin
            v_q[0] <= in_v;
            for (int i = 1; i < RD_LAT; i++) v_q[i] <= v_q[i-1];
        end
    end

    // Payload shifts unconditionally; it is only meaningful where valid is set.
    always_ff @(posedge clk) begin
        exp_q[0]   <= in_exp;
        addr_q[0]  <= in_addr;
        phase_q[0] <= in_phase;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_q[i]   <= exp_q[i-1];
            addr_q[i]  <= addr_q[i-1];
            phase_q[i] <= phase_q[i-1];
        end
    end

    assign out_v     = v_q[RD_LAT-1];
    assign out_exp   = exp_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];
    assign out_phase = phase_q[RD_LAT-1];

endmodule

// File: rtl/sp_ram_bist.sv
// March BIST initiator for sp_ram: W0 up, R/W up, R/W down, R down, then drain
// outstanding reads. Captures the first mismatch and aborts into DRAIN on it.
import sp_ram_bist_pkg::*;

module sp_ram_bist #(
    parameter int               WIDTH  = 8,
    parameter int               ADDR   = 4,
    parameter int               RD_LAT = 1,
    parameter logic [WIDTH-1:0] PAT    = {WIDTH/2{2'b01}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ADDR-1:0]  fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic [1:0]       fail_phase,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout
);

    localparam int              CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR-1:0] A_LAST = '1;
    localparam logic [CW-1:0]   C_LAST = CW'(RD_LAT - 1);

    state_t           state;
    logic             rw_wr;      // in RW elements: current op is the write half
    logic [CW-1:0]    drain_cnt;
    logic             fail_seen;
    logic             iss_v;      // current mem op is a read to be checked
    logic [WIDTH-1:0] iss_exp;
    logic [1:0]       iss_phase;

    logic             cmp_v;
    logic [WIDTH-1:0] cmp_exp;
    logic [ADDR-1:0]  cmp_addr;
    logic [1:0]       cmp_phase;
    logic             mismatch;

    bist_rd_pipe #(.WIDTH(WIDTH), .ADDR(ADDR), .RD_LAT(RD_LAT)) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_v      (iss_v),
        .in_exp    (iss_exp),
        .in_addr   (mem_addr),
        .in_phase  (iss_phase),
        .out_v     (cmp_v),
        .out_exp   (cmp_exp),
        .out_addr  (cmp_addr),
        .out_phase (cmp_phase)
    );

    assign mismatch = cmp_v && (mem_dout != cmp_exp);

    // Main controller: sequences the march elements, drives the RAM port, captures first failure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_phase <= PH_NONE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            rw_wr      <= 1'b0;
            drain_cnt  <= '0;
            fail_seen  <= 1'b0;
            iss_v      <= 1'b0;
            iss_exp    <= '0;
            iss_phase  <= PH_NONE;
        end else begin
            // Default to an idle RAM cycle; each state overrides for its next op.
            mem_we  <= 1'b0;
            mem_din <= '0;
            iss_v   <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= W0_UP;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_seen  <= 1'b0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        fail_phase <= PH_NONE;
                        mem_addr   <= '0;
                        mem_we     <= 1'b1;
                        mem_din    <= PAT;
                    end
                end
                W0_UP: begin
                    if (mem_addr == A_LAST) begin
                        state     <= RW_UP;
                        mem_addr  <= '0;
                        rw_wr     <= 1'b0;
                        iss_v     <= 1'b1;
                        iss_exp   <= PAT;
                        iss_phase <= PH_RW_UP;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        mem_we   <= 1'b1;
                        mem_din  <= PAT;
                    end
                end
                RW_UP: begin
                    if (!rw_wr) begin
                        rw_wr   <= 1'b1;
                        mem_we  <= 1'b1;
                        mem_din <= ~PAT;
                    end else if (mem_addr == A_LAST) begin
                        state     <= RW_DN;
                        rw_wr     <= 1'b0;
                        iss_v     <= 1'b1;
                        iss_exp   <= ~PAT;
                        iss_phase <= PH_RW_DN;
                    end else begin
                        mem_addr  <= mem_addr + 1'b1;
                        rw_wr     <= 1'b0;
                        iss_v     <= 1'b1;
                        iss_exp   <= PAT;
                        iss_phase <= PH_RW_UP;
                    end
                end
                RW_DN: begin
                    if (!rw_wr) begin
                        rw_wr   <= 1'b1;
                        mem_we  <= 1'b1;
                        mem_din <= PAT;
                    end else if (mem_addr == '0) begin
                        state     <= R_DN;
                        mem_addr  <= A_LAST;
                        rw_wr     <= 1'b0;
                        iss_v     <= 1'b1;
                        iss_exp   <= PAT;
                        iss_phase <= PH_R_DN;
                    end else begin
                        mem_addr  <= mem_addr - 1'b1;
                        rw_wr     <= 1'b0;
                        iss_v     <= 1'b1;
                        iss_exp   <= ~PAT;
                        iss_phase <= PH_RW_DN;
                    end
                end
                R_DN: begin
                    if (mem_addr == '0) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        mem_addr  <= mem_addr - 1'b1;
                        iss_v     <= 1'b1;
                        iss_exp   <= PAT;
                        iss_phase <= PH_R_DN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == C_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !(fail_seen || mismatch);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // First mismatch wins; it also cancels any op chosen above and heads to DRAIN.
            if (mismatch && !fail_seen) begin
                fail_seen  <= 1'b1;
                fail_addr  <= cmp_addr;
                fail_data  <= mem_dout;
                fail_phase <= cmp_phase;
                if (state != DRAIN) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                    mem_we    <= 1'b0;
                    mem_din   <= '0;
                    iss_v     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_bist.sv
// Bench for sp_ram_bist with a behavioural 1-cycle-latency sp_ram and fault injection.
module tb_sp_ram_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic [1:0] fail_phase;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout = 8'h00;

    int n_checks = 0;
    int n_fails  = 0;

    // 0 = clean, 1 = bit0 stuck-at-0 reading addr 5, 2 = write to 3 also writes 7
    int         fault_mode = 0;
    logic [7:0] ram [16];
    logic [7:0] rd_val;
    int         wr_n = 0;
    logic [3:0] wr_addr [64];
    logic [7:0] wr_data [64];

    sp_ram_bist dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_phase (fail_phase),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural sp_ram (read-before-write) plus write log
    always @(posedge clk) begin
        rd_val = ram[mem_addr];
        if (fault_mode == 1 && mem_addr == 4'd5) rd_val[0] = 1'b0;
        mem_dout <= rd_val;
        if (mem_we) begin
            ram[mem_addr] <= mem_din;
            if (fault_mode == 2 && mem_addr == 4'd3) ram[7] <= mem_din;
            if (wr_n < 64) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_din;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    endtask

    // Pulse start, then count edges until done (bounded). Edge 0 is the start-sampling edge.
    task automatic run_test(input bit ign, input int late_from, output int n, output int late_we);
        n = 0;
        late_we = 0;
        wr_n = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n >= late_from && mem_we) late_we++;
            start = ign && (n == 9 || n == 49);
            if (done) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int         fault;
        bit         ign;
        bit         exp_pass;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic [1:0] exp_phase;
        int         exp_edge;
        int         late_from;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n, late, bad;

        vecs[0] = '{0, 1'b0, 1'b1, 4'd0, 8'h00, 2'd0, 97, 96};
        vecs[1] = '{1, 1'b0, 1'b0, 4'd5, 8'h54, 2'd1, 29, 28};
        vecs[2] = '{2, 1'b0, 1'b0, 4'd7, 8'hAA, 2'd1, 33, 32};
        vecs[3] = '{0, 1'b1, 1'b1, 4'd0, 8'h00, 2'd0, 97, 96};

        clear_ram();

        // 1: reset held 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_we", mem_we, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_fail_data", fail_data, 0);
        check("rst_fail_phase", fail_phase, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        @(negedge clk);
        rst = 1'b0;

        // 2-5: table-driven runs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fault_mode = vecs[i].fault;
            clear_ram();
            run_test(vecs[i].ign, vecs[i].late_from, n, late);
            check($sformatf("v%0d_done_edge", i), n, vecs[i].exp_edge);
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_busy", i), busy, 0);
            check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
            check($sformatf("v%0d_fail_addr", i), fail_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_fail_data", i), fail_data, vecs[i].exp_data);
            check($sformatf("v%0d_fail_phase", i), fail_phase, vecs[i].exp_phase);
            check($sformatf("v%0d_late_we", i), late, 0);
            if (i == 0) begin
                check("clean_write_count", wr_n, 48);
                for (int a = 0; a < 16; a++) begin
                    check($sformatf("w0_addr%0d", a), wr_addr[a], a);
                    check($sformatf("w0_data%0d", a), wr_data[a], 8'h55);
                end
                bad = 0;
                for (int a = 0; a < 16; a++) if (ram[a] !== 8'h55) bad++;
                check("ram_final_55", bad, 0);
            end
        end

        // 6: reset mid-run at cycle 40, then restart
        @(negedge clk);
        fault_mode = 0;
        clear_ram();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        wr_n = 0;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_writes", wr_n, 0);
        check("abort_done_low", done, 0);
        run_test(1'b0, 96, n, late);
        check("restart_done_edge", n, 97);
        check("restart_pass", pass, 1);
        check("restart_late_we", late, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
